serial_bit_feeder: RTL and testbench

Upstream stage of the serial sequence-detector FSM. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `x`, which drives the detector's `x` input. A one-word holding buffer allows consecutive words to stream with no gap bits. An `enable` input stalls shifting without losing data.

---
 rtl/serial_bit_feeder.sv | 97 +++++++++
 tb/tb_serial_bit_feeder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel-to-serial bit feeder with one-word hold buffer
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             enable,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hb;
  logic             hb_full;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sr_next;

  // Handshake, serial output and the "last bit consumed this edge" condition
  always_comb begin
    din_ready = !hb_full && !reset;
    accept    = din_valid && din_ready;
    x_valid   = (state == SHIFT) && enable;
    last_bit  = x_valid && (cnt == LAST);
    busy      = (state == SHIFT) || hb_full;
    x         = IDLE_BIT;
    if (state == SHIFT) begin
      x = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    end
    // Shift toward the output end; the fill bit never reaches x before a reload
    sr_next = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  end

  // Shifter FSM, hold buffer and registered word_done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      hb        <= '0;
      hb_full   <= 1'b0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= last_bit;
      case (state)
        IDLE: begin
          if (accept) begin
            sr    <= din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (hb_full) begin
              // Gapless hand-off; din_ready was low so no accept can collide
              sr      <= hb;
              hb_full <= 1'b0;
              cnt     <= '0;
            end else if (accept) begin
              sr  <= din;
              cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (enable) begin
              sr  <= sr_next;
              cnt <= cnt + 1'b1;
            end
            if (accept) begin
              hb      <= din;
              hb_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - table-driven bench for serial_bit_feeder
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       enable;

  logic dr_m, x_m, xv_m, busy_m, wd_m;
  logic dr_l, x_l, xv_l, busy_l, wd_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(dr_m),
    .enable(enable), .x(x_m), .x_valid(xv_m), .busy(busy_m), .word_done(wd_m)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(dr_l),
    .enable(enable), .x(x_l), .x_valid(xv_l), .busy(busy_l), .word_done(wd_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One word through both instances with enable held high
  task automatic run_word(input logic [7:0] d, input logic [7:0] em, input logic [7:0] el);
    din = d; din_valid = 1'b1; enable = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("word %0h msb bit %0d", d, i), x_m, em[7-i]);
      check($sformatf("word %0h lsb bit %0d", d, i), x_l, el[7-i]);
      check($sformatf("word %0h x_valid %0d", d, i), xv_m, 1'b1);
      check($sformatf("word %0h no early done %0d", d, i), wd_m, 1'b0);
      if (i < 7) tick;
    end
    tick;
    check($sformatf("word %0h done msb", d), wd_m, 1'b1);
    check($sformatf("word %0h done lsb", d), wd_l, 1'b1);
    check($sformatf("word %0h idle x", d), x_m, 1'b0);
    check($sformatf("word %0h idle x_valid", d), xv_m, 1'b0);
    check($sformatf("word %0h idle busy", d), busy_m, 1'b0);
    tick;
    check($sformatf("word %0h done pulse end", d), wd_m, 1'b0);
  endtask

  // Two words: second offered in cycle 'offer' (1 = via hold buffer, 8 = direct bypass)
  task automatic stream2(input logic [7:0] w0, input logic [7:0] w1, input int offer);
    logic [15:0] seq;
    seq = {w0, w1};
    din = w0; din_valid = 1'b1; enable = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == offer) begin
        din = w1; din_valid = 1'b1;
        #1;
      end
      if (c <= 16) begin
        check($sformatf("stream%0d x c%0d", offer, c), x_m, seq[16-c]);
        check($sformatf("stream%0d x_valid c%0d", offer, c), xv_m, 1'b1);
      end else begin
        check($sformatf("stream%0d idle x", offer), x_m, 1'b0);
        check($sformatf("stream%0d idle busy", offer), busy_m, 1'b0);
      end
      check($sformatf("stream%0d word_done c%0d", offer, c), wd_m, (c == 9 || c == 17));
      check($sformatf("stream%0d din_ready c%0d", offer, c), dr_m,
            !(offer == 1 && c >= 2 && c <= 8));
      if (c < 17) tick;
      din_valid = 1'b0;
    end
    tick;
  endtask

  logic en_t[12];
  logic x_t[12];

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h0B, 8'h0B, 8'hD0};
    vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[4] = '{8'h01, 8'h01, 8'h80};
    vecs[5] = '{8'h81, 8'h81, 8'h81};
    en_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    x_t  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; din = 8'h00; din_valid = 1'b0; enable = 1'b1;
    #1;
    check("reset x", x_m, 1'b0);
    check("reset x_valid", xv_m, 1'b0);
    check("reset busy", busy_m, 1'b0);
    check("reset din_ready", dr_m, 1'b0);
    check("reset word_done", wd_m, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("release din_ready", dr_m, 1'b1);

    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v].din, vecs[v].exp_msb, vecs[v].exp_lsb);
    end

    stream2(8'hA5, 8'h3C, 1);
    stream2(8'hF0, 8'h01, 8);

    // Stall: enable low for three cycles while the third bit is on x
    din = 8'hA5; din_valid = 1'b1; enable = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) begin
        enable = en_t[c];
        #1;
        check($sformatf("stall x c%0d", c), x_m, x_t[c]);
        check($sformatf("stall x_valid c%0d", c), xv_m, en_t[c]);
        check($sformatf("stall word_done c%0d", c), wd_m, 1'b0);
      end else begin
        enable = 1'b1;
        check("stall word_done late", wd_m, 1'b1);
        check("stall idle x", x_m, 1'b0);
      end
      if (c < 12) tick;
    end
    tick;
    check("stall done pulse end", wd_m, 1'b0);

    // Reset mid-word with the hold buffer occupied
    din = 8'hFF; din_valid = 1'b1; enable = 1'b1;
    tick;
    din = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("pre-reset x c%0d", c), x_m, 1'b1);
      tick;
      din_valid = 1'b0;
    end
    check("pre-reset hold busy", busy_m, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midreset x", x_m, 1'b0);
    check("midreset x_valid", xv_m, 1'b0);
    check("midreset busy", busy_m, 1'b0);
    check("midreset din_ready", dr_m, 1'b0);
    check("midreset word_done", wd_m, 1'b0);
    tick;
    check("in reset word_done", wd_m, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("post reset din_ready", dr_m, 1'b1);
    check("post reset busy", busy_m, 1'b0);
    run_word(8'h81, 8'h81, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
